// File: rtl/membus_arbiter_pkg.sv
// Package eei: shared widths and types for the memory-bus arbiter.
//   XLEN               default address width
//   MEMBUS_DATA_WIDTH  default data width (multiple of 8)
//   MEMBUS_ARB_NMST    number of requesters behind the arbiter
//   membus_arb_state_t arbiter FSM states
//   membus_arb_id_t    requester index (0 = instruction fetch, 1 = load/store)
package eei;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned MEMBUS_DATA_WIDTH = 32;
  localparam int unsigned MEMBUS_ARB_NMST   = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    WAIT_RESP = 2'd2
  } membus_arb_state_t;

  typedef logic membus_arb_id_t;

endpackage

// File: rtl/membus_if.sv
// Membus: single-outstanding request/response memory bus.
//   valid/ready  request handshake (requester -> memory)
//   addr/wen/wdata/wmask request payload
//   rvalid/rdata response, one per accepted request
// Modports: master drives the request, slave drives ready and the response.
interface Membus #(
  parameter int unsigned DATA_WIDTH = eei::MEMBUS_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = eei::XLEN
);

  logic                    valid;
  logic                    ready;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    wen;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wmask;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/membus_arb_pick.sv
// membus_arb_pick: combinational winner selection for the memory-bus arbiter.
//   i_valid[1:0]  request valid per requester (bit 1 = load/store)
//   i_last_owner  requester granted on the most recent acceptance
//   o_winner      index of the requester to grant
// Build option MEMBUS_ARB_RR_EN: on a tie the requester that was not granted
// last wins; otherwise load/store always beats instruction fetch.
module membus_arb_pick
  import eei::*;
(
  input  logic [MEMBUS_ARB_NMST-1:0] i_valid,
  input  membus_arb_id_t             i_last_owner,
  output membus_arb_id_t             o_winner
);

`ifdef MEMBUS_ARB_RR_EN
  always_comb begin
    o_winner = 1'b0;
    unique case (i_valid)
      2'b01:   o_winner = 1'b0;
      2'b10:   o_winner = 1'b1;
      2'b11:   o_winner = ~i_last_owner;
      default: o_winner = 1'b0;
    endcase
  end
`else
  // last_owner is only consulted by the round-robin build.
  logic w_unused_last_owner;
  assign w_unused_last_owner = i_last_owner;

  always_comb begin
    o_winner = 1'b0;
    unique case (i_valid)
      2'b01:   o_winner = 1'b0;
      2'b10:   o_winner = 1'b1;
      2'b11:   o_winner = 1'b1;
      default: o_winner = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/membus_arbiter.sv
// membus_arbiter: shares one downstream Membus between an instruction-fetch
// requester (index 0) and a load/store requester (index 1), one outstanding
// transaction at a time. Request path and response path are combinational.
//   clk           clock, all state on rising edge
//   rst_n         synchronous active-low reset
//   i_mst         instruction-fetch requester (Membus.slave)
//   d_mst         load/store requester (Membus.slave)
//   s_bus         shared memory (Membus.master)
//   busy          high whenever the FSM is not in IDLE
//   err_spurious  sticky: a response arrived with nothing outstanding
// Build option MEMBUS_ARB_RR_EN selects round-robin tie-break (see membus_arb_pick).
//
// state     | meaning
// IDLE      | no grant held; arbitrate among valid requesters (skipped for one
//           | bubble cycle right after a response)
// HOLD      | grant locked to owner, waiting for s_bus.ready
// WAIT_RESP | request accepted, waiting for s_bus.rvalid
module membus_arbiter
  import eei::*;
#(
  parameter int unsigned DATA_WIDTH = MEMBUS_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = XLEN
) (
  input  logic  clk,
  input  logic  rst_n,
  Membus.slave  i_mst,
  Membus.slave  d_mst,
  Membus.master s_bus,
  output logic  busy,
  output logic  err_spurious
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  membus_arb_state_t r_state;
  membus_arb_state_t w_next_state;
  membus_arb_id_t    r_owner;
  membus_arb_id_t    r_last_owner;
  membus_arb_id_t    w_winner;
  membus_arb_id_t    w_sel;
  logic              r_bubble;
  logic              r_err;

  logic [MEMBUS_ARB_NMST-1:0] w_valid;
  logic                       w_drive;
  logic                       w_accept;
  logic                       w_resp;
  logic                       w_spurious;

  logic                  w_req_valid;
  logic                  w_req_wen;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [DATA_WIDTH-1:0] w_req_wdata;
  logic [MASK_WIDTH-1:0] w_req_wmask;

  assign w_valid = {d_mst.valid, i_mst.valid};

  membus_arb_pick u_pick (
    .i_valid      (w_valid),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner)
  );

  // Once a request is presented but not accepted the grant is frozen.
  assign w_sel = (r_state == HOLD) ? r_owner : w_winner;

  assign w_req_valid = w_sel ? d_mst.valid : i_mst.valid;
  assign w_req_wen   = w_sel ? d_mst.wen   : i_mst.wen;
  assign w_req_addr  = w_sel ? d_mst.addr  : i_mst.addr;
  assign w_req_wdata = w_sel ? d_mst.wdata : i_mst.wdata;
  assign w_req_wmask = w_sel ? d_mst.wmask : i_mst.wmask;

  always_comb begin
    w_next_state = r_state;
    w_drive      = 1'b0;
    w_accept     = 1'b0;
    w_resp       = 1'b0;
    w_spurious   = 1'b0;

    if (rst_n) begin
      unique case (r_state)
        IDLE: begin
          w_spurious = s_bus.rvalid;
          if (!r_bubble && (w_valid != '0)) begin
            w_drive      = 1'b1;
            w_accept     = s_bus.ready;
            w_next_state = s_bus.ready ? WAIT_RESP : HOLD;
          end
        end
        HOLD: begin
          w_spurious = s_bus.rvalid;
          w_drive    = 1'b1;
          w_accept   = w_req_valid & s_bus.ready;
          if (w_accept) w_next_state = WAIT_RESP;
        end
        WAIT_RESP: begin
          w_resp = s_bus.rvalid;
          if (w_resp) w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end

    // Everything below is forced to zero while in reset via w_drive/w_resp.
    s_bus.valid  = w_drive & w_req_valid;
    s_bus.wen    = w_drive & w_req_wen;
    s_bus.addr   = w_drive ? w_req_addr  : '0;
    s_bus.wdata  = w_drive ? w_req_wdata : '0;
    s_bus.wmask  = w_drive ? w_req_wmask : '0;

    i_mst.ready  = w_drive & w_req_valid & s_bus.ready & (w_sel == 1'b0);
    d_mst.ready  = w_drive & w_req_valid & s_bus.ready & (w_sel == 1'b1);

    i_mst.rvalid = w_resp & (r_owner == 1'b0);
    d_mst.rvalid = w_resp & (r_owner == 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b0;
      r_bubble     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && w_drive) r_owner <= w_sel;
      if (w_accept) r_last_owner <= w_sel;
      // One idle cycle after every response before a new grant.
      r_bubble <= w_resp;
      if (w_spurious) r_err <= 1'b1;
    end
  end

  assign i_mst.rdata  = s_bus.rdata;
  assign d_mst.rdata  = s_bus.rdata;
  assign busy         = (r_state != IDLE);
  assign err_spurious = r_err;

endmodule

// File: tb/tb_membus_arbiter.sv
module tb_membus_arbiter;

`ifdef MEMBUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic busy;
  logic err_spurious;

  Membus #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) i_bus ();
  Membus #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) d_bus ();
  Membus #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s_if ();

  membus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_mst        (i_bus),
    .d_mst        (d_bus),
    .s_bus        (s_if),
    .busy         (busy),
    .err_spurious (err_spurious)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: who has a request pending, whether one is
  // in flight, and whether the post-response gap cycle is still due.
  bit   mon_en   = 1'b0;
  int   m_held   = -1;
  bit   m_out    = 1'b0;
  int   m_owner  = 0;
  bit   m_bubble = 1'b0;
  bit   m_last   = 1'b0;
  bit   m_err    = 1'b0;

  logic [1:0]  mv;
  int          cand;
  logic        e_sv, e_wen, e_busy, e_err;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wmask;
  logic [1:0]  e_rdy, e_rv;

  // Observations used by the directed literal checks.
  int          n_cyc = 0;
  int          n_busy = 0;
  bit          g_acc_i = 1'b0, g_acc_d = 1'b0, g_acc_s = 1'b0;
  logic [31:0] g_acc_addr = '0;
  int          rv_own[$];
  logic [31:0] rv_dat[$];
  int          acc_cyc[$];

  always @(negedge clk) begin
    if (mon_en) begin
      mv = {d_bus.valid, i_bus.valid};
      e_sv = 0; e_wen = 0; e_addr = '0; e_wdata = '0; e_wmask = '0;
      e_rdy = '0; e_rv = '0;
      e_busy = (m_held >= 0) || m_out;
      e_err  = m_err;
      cand   = -1;
      if (rst_n) begin
        if (m_out) begin
          if (s_if.rvalid) e_rv[m_owner] = 1'b1;
        end else if (!m_bubble) begin
          if (m_held >= 0)       cand = m_held;
          else if (mv == 2'b11)  cand = RR ? (m_last ? 0 : 1) : 1;
          else if (mv[1])        cand = 1;
          else if (mv[0])        cand = 0;
          if (cand >= 0 && mv[cand]) begin
            e_sv = 1'b1;
            if (cand == 1) begin
              e_addr = d_bus.addr; e_wen = d_bus.wen; e_wdata = d_bus.wdata; e_wmask = d_bus.wmask;
            end else begin
              e_addr = i_bus.addr; e_wen = i_bus.wen; e_wdata = i_bus.wdata; e_wmask = i_bus.wmask;
            end
            e_rdy[cand] = s_if.ready;
          end
        end
      end

      chk("s_valid", 64'(s_if.valid), 64'(e_sv));
      if (e_sv || !rst_n) begin
        chk("s_addr",  64'(s_if.addr),  64'(e_addr));
        chk("s_wen",   64'(s_if.wen),   64'(e_wen));
        chk("s_wdata", 64'(s_if.wdata), 64'(e_wdata));
        chk("s_wmask", 64'(s_if.wmask), 64'(e_wmask));
      end
      chk("i_ready",  64'(i_bus.ready),  64'(e_rdy[0]));
      chk("d_ready",  64'(d_bus.ready),  64'(e_rdy[1]));
      chk("i_rvalid", 64'(i_bus.rvalid), 64'(e_rv[0]));
      chk("d_rvalid", 64'(d_bus.rvalid), 64'(e_rv[1]));
      chk("i_rdata",  64'(i_bus.rdata),  64'(s_if.rdata));
      chk("d_rdata",  64'(d_bus.rdata),  64'(s_if.rdata));
      chk("busy",     64'(busy),         64'(e_busy));
      chk("err",      64'(err_spurious), 64'(e_err));

      if (busy) n_busy++;
      if (i_bus.rvalid) begin rv_own.push_back(0); rv_dat.push_back(i_bus.rdata); end
      if (d_bus.rvalid) begin rv_own.push_back(1); rv_dat.push_back(d_bus.rdata); end
      g_acc_i = i_bus.valid & i_bus.ready;
      g_acc_d = d_bus.valid & d_bus.ready;
      g_acc_s = s_if.valid & s_if.ready;
      if (g_acc_s) g_acc_addr = s_if.addr;
      if (g_acc_i) acc_cyc.push_back(n_cyc);
      n_cyc++;

      if (!rst_n) begin
        m_held = -1; m_out = 0; m_bubble = 0; m_last = 0; m_err = 0;
      end else if (m_out) begin
        if (s_if.rvalid) begin m_out = 0; m_bubble = 1; end
      end else begin
        if (s_if.rvalid) m_err = 1;
        if (m_bubble) m_bubble = 0;
        else if (cand >= 0 && mv[cand]) begin
          if (s_if.ready) begin
            m_out = 1; m_owner = cand; m_last = (cand == 1); m_held = -1;
          end else begin
            m_held = cand;
          end
        end
      end
    end
  end

  // Advance one cycle; a requester drops valid once its request is taken.
  task automatic step();
    @(posedge clk); #1;
    if (g_acc_i) i_bus.valid = 1'b0;
    if (g_acc_d) d_bus.valid = 1'b0;
  endtask

  // Same, with a memory that answers one cycle after each acceptance.
  task automatic step_resp();
    step();
    s_if.rvalid = g_acc_s;
    s_if.rdata  = 32'hC0DE_0000 | g_acc_addr;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic contend(input string tag, input int first);
    rv_own.delete(); rv_dat.delete();
    i_bus.valid = 1; i_bus.addr = 32'h100; i_bus.wen = 0; i_bus.wdata = '0; i_bus.wmask = '0;
    d_bus.valid = 1; d_bus.addr = 32'h200; d_bus.wen = 1; d_bus.wdata = 32'h55; d_bus.wmask = 4'hF;
    s_if.ready = 1;
    at_neg();
    chk({tag, "_first_addr"}, 64'(s_if.addr), (first == 1) ? 64'h200 : 64'h100);
    for (int k = 0; k < 12 && rv_own.size() < 2; k++) step_resp();
    s_if.rvalid = 0;
    chk({tag, "_nresp"}, 64'(rv_own.size()), 64'd2);
    if (rv_own.size() >= 2) begin
      chk({tag, "_owner0"}, 64'(rv_own[0]), 64'(first));
      chk({tag, "_owner1"}, 64'(rv_own[1]), 64'(1 - first));
      chk({tag, "_data0"}, 64'(rv_dat[0]), (first == 1) ? 64'hC0DE_0200 : 64'hC0DE_0100);
      chk({tag, "_data1"}, 64'(rv_dat[1]), (first == 1) ? 64'hC0DE_0100 : 64'hC0DE_0200);
    end
    s_if.ready = 0;
    step(); step();
  endtask

  int nacc;

  initial begin
    rst_n = 0;
    i_bus.valid = 0; i_bus.addr = '0; i_bus.wen = 0; i_bus.wdata = '0; i_bus.wmask = '0;
    d_bus.valid = 0; d_bus.addr = '0; d_bus.wen = 0; d_bus.wdata = '0; d_bus.wmask = '0;
    s_if.ready = 0; s_if.rvalid = 0; s_if.rdata = '0;
    @(posedge clk); #1;
    mon_en = 1;

    // Reset: a valid request must not leak through while rst_n is low.
    d_bus.valid = 1; d_bus.addr = 32'h55; s_if.ready = 1;
    at_neg();
    chk("rst_s_valid", 64'(s_if.valid), 64'd0);
    chk("rst_s_addr",  64'(s_if.addr),  64'd0);
    chk("rst_d_ready", 64'(d_bus.ready), 64'd0);
    step();
    d_bus.valid = 0; s_if.ready = 0; rst_n = 1;
    at_neg();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err",  64'(err_spurious), 64'd0);
    step();

    // Single read, response two cycles after acceptance.
    n_busy = 0; rv_own.delete(); rv_dat.delete();
    i_bus.valid = 1; i_bus.addr = 32'h100; s_if.ready = 1;
    step();
    s_if.ready = 0;
    step();
    s_if.rvalid = 1; s_if.rdata = 32'hDEAD_BEEF;
    at_neg();
    chk("t1_i_rvalid", 64'(i_bus.rvalid), 64'd1);
    chk("t1_i_rdata",  64'(i_bus.rdata),  64'hDEAD_BEEF);
    chk("t1_d_rvalid", 64'(d_bus.rvalid), 64'd0);
    step();
    s_if.rvalid = 0;
    step(); step();
    chk("t1_busy_cycles", 64'(n_busy), 64'd2);

    // Contention; last owner is instruction fetch here, so d wins either way.
    contend("t2", 1);

    // Make load/store the last owner, then contend again.
    rv_own.delete(); rv_dat.delete();
    d_bus.valid = 1; d_bus.addr = 32'h240; d_bus.wen = 0; s_if.ready = 1;
    for (int k = 0; k < 8 && rv_own.size() < 1; k++) step_resp();
    s_if.rvalid = 0;
    chk("t2b_pre_nresp", 64'(rv_own.size()), 64'd1);
    if (rv_own.size() >= 1) chk("t2b_pre_data", 64'(rv_dat[0]), 64'hC0DE_0240);
    step(); step();
    contend("t2b", RR ? 0 : 1);

    // Backpressure: grant stays with d while the memory stalls.
    rv_own.delete(); rv_dat.delete();
    d_bus.valid = 1; d_bus.addr = 32'h300; d_bus.wen = 0; s_if.ready = 0;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk("t3_s_addr",  64'(s_if.addr),   64'h300);
      chk("t3_i_ready", 64'(i_bus.ready), 64'd0);
      step();
      if (c == 0) begin i_bus.valid = 1; i_bus.addr = 32'h400; i_bus.wen = 0; end
    end
    s_if.ready = 1;
    for (int k = 0; k < 12 && rv_own.size() < 2; k++) step_resp();
    s_if.rvalid = 0; s_if.ready = 0;
    chk("t3_nresp", 64'(rv_own.size()), 64'd2);
    if (rv_own.size() >= 2) begin
      chk("t3_owner0", 64'(rv_own[0]), 64'd1);
      chk("t3_owner1", 64'(rv_own[1]), 64'd0);
      chk("t3_data1",  64'(rv_dat[1]), 64'hC0DE_0400);
    end
    step(); step();

    // Spurious response in IDLE.
    at_neg();
    chk("t4_err_before", 64'(err_spurious), 64'd0);
    step();
    s_if.rvalid = 1; s_if.rdata = 32'h1234;
    at_neg();
    chk("t4_i_rvalid", 64'(i_bus.rvalid), 64'd0);
    chk("t4_d_rvalid", 64'(d_bus.rvalid), 64'd0);
    step();
    s_if.rvalid = 0;
    at_neg();
    chk("t4_err", 64'(err_spurious), 64'd1);
    step(); step(); step();
    at_neg();
    chk("t4_err_sticky", 64'(err_spurious), 64'd1);
    step();

    // Reset while waiting for a response; the late response is spurious.
    rst_n = 0;
    step();
    rst_n = 1;
    at_neg();
    chk("t5_err_cleared", 64'(err_spurious), 64'd0);
    step();
    i_bus.valid = 1; i_bus.addr = 32'h500; s_if.ready = 1;
    step();
    s_if.ready = 0; rst_n = 0;
    step();
    rst_n = 1; s_if.rvalid = 1; s_if.rdata = 32'h5A5A;
    at_neg();
    chk("t5_i_rvalid", 64'(i_bus.rvalid), 64'd0);
    chk("t5_busy",     64'(busy),         64'd0);
    step();
    s_if.rvalid = 0;
    at_neg();
    chk("t5_err", 64'(err_spurious), 64'd1);
    step(); step();

    // Back-to-back fetches with a one-cycle memory.
    rv_own.delete(); rv_dat.delete(); acc_cyc.delete();
    nacc = 0;
    i_bus.valid = 1; i_bus.addr = 32'h1000; i_bus.wen = 0; s_if.ready = 1;
    for (int c = 0; c < 40 && rv_own.size() < 4; c++) begin
      @(posedge clk); #1;
      s_if.rvalid = g_acc_s;
      s_if.rdata  = 32'hC0DE_0000 | g_acc_addr;
      if (g_acc_i) begin
        nacc++;
        if (nacc < 4) i_bus.addr = 32'h1000 + 32'(nacc * 4);
        else          i_bus.valid = 0;
      end
    end
    s_if.rvalid = 0; s_if.ready = 0;
    chk("t6_nacc",  64'(acc_cyc.size()), 64'd4);
    chk("t6_nresp", 64'(rv_own.size()),  64'd4);
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("t6_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd3);
    for (int k = 0; k < rv_own.size(); k++) begin
      chk("t6_owner", 64'(rv_own[k]), 64'd0);
      chk("t6_data",  64'(rv_dat[k]), 64'(32'hC0DE_1000 + 32'(k * 4)));
    end
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
